// File: rtl/pkt_egress_reader.sv
// rtl/pkt_egress_reader.sv - descriptor-driven packet buffer reader with SOP/EOP egress stream
module pkt_egress_reader #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10,
    parameter int LWIDTH = 6,
    parameter int MWIDTH = 64,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sch_valid,
    output logic              sch_deque_en,
    input  logic [DWIDTH-1:0] sch_data,
    output logic              mem_rd_en,
    output logic [AWIDTH-1:0] mem_rd_addr,
    input  logic [MWIDTH-1:0] mem_rd_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [MWIDTH-1:0] tx_data,
    output logic              tx_sop,
    output logic              tx_eop,
    output logic              free_valid,
    output logic [AWIDTH-1:0] free_addr,
    output logic              busy,
    output logic [CWIDTH-1:0] pkt_cnt
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] start_q;
    logic [LWIDTH-1:0] len_q, idx_q;
    logic              inflight_q, infl_sop_q, infl_eop_q;
    logic [MWIDTH-1:0] buf_data [2];
    logic [1:0]        buf_sop, buf_eop, occ;
    logic              rd_ptr, wr_ptr;
    logic              free_valid_q;
    logic [AWIDTH-1:0] free_addr_q;
    logic [CWIDTH-1:0] pkt_cnt_q;

    logic [AWIDTH-1:0] desc_start;
    logic [LWIDTH-1:0] desc_len;
    logic              unused_desc_bits;
    logic              buf_has, pop, buf_wr, buf_rd, issue_ok, last_issue;
    logic [2:0]        credit;

    assign desc_start       = sch_data[AWIDTH-1:0];
    assign desc_len         = sch_data[AWIDTH+LWIDTH-1:AWIDTH];
    assign unused_desc_bits = ^sch_data[DWIDTH-1:AWIDTH+LWIDTH];

    // The word returning from RAM is presented directly when the buffer is empty,
    // so it only lands in the buffer if the sink does not take it this cycle.
    assign buf_has  = (occ != 2'd0);
    assign tx_valid = buf_has | inflight_q;
    assign tx_data  = !tx_valid ? '0 : (buf_has ? buf_data[rd_ptr] : mem_rd_data);
    assign tx_sop   = tx_valid & (buf_has ? buf_sop[rd_ptr] : infl_sop_q);
    assign tx_eop   = tx_valid & (buf_has ? buf_eop[rd_ptr] : infl_eop_q);
    assign pop      = tx_valid & tx_ready;
    assign buf_wr   = inflight_q & ~(~buf_has & pop);
    assign buf_rd   = buf_has & pop;

    // Words still owed to the sink after this cycle; a new read is allowed only
    // if that leaves room for it in the two-entry buffer.
    assign credit   = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue_ok = (credit < 3'd2);

    assign mem_rd_addr = mem_rd_en ? start_q + AWIDTH'(idx_q) : '0;
    assign last_issue  = (idx_q == len_q - LWIDTH'(1));
    assign free_valid  = free_valid_q;
    assign free_addr   = free_addr_q;
    assign pkt_cnt     = pkt_cnt_q;
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        sch_deque_en = 1'b0;
        mem_rd_en    = 1'b0;
        case (state)
            IDLE: begin
                if (sch_valid) begin
                    sch_deque_en = 1'b1;
                    if (desc_len != '0) state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (issue_ok) begin
                    mem_rd_en = 1'b1;
                    if (last_issue) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && tx_eop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            start_q      <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            inflight_q   <= 1'b0;
            infl_sop_q   <= 1'b0;
            infl_eop_q   <= 1'b0;
            buf_sop      <= '0;
            buf_eop      <= '0;
            occ          <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            free_valid_q <= 1'b0;
            free_addr_q  <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            state        <= state_nxt;
            free_valid_q <= 1'b0;
            inflight_q   <= mem_rd_en;
            if (sch_deque_en) begin
                start_q <= desc_start;
                len_q   <= desc_len;
                idx_q   <= '0;
                if (desc_len == '0) begin
                    free_valid_q <= 1'b1;
                    free_addr_q  <= desc_start;
                end
            end
            if (mem_rd_en) begin
                idx_q      <= idx_q + LWIDTH'(1);
                infl_sop_q <= (idx_q == '0);
                infl_eop_q <= last_issue;
            end
            if (buf_wr) begin
                buf_sop[wr_ptr] <= infl_sop_q;
                buf_eop[wr_ptr] <= infl_eop_q;
                wr_ptr          <= ~wr_ptr;
            end
            if (buf_rd) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, buf_wr} - {1'b0, buf_rd};
            if (state == DRAIN && pop && tx_eop) begin
                free_valid_q <= 1'b1;
                free_addr_q  <= start_q;
                pkt_cnt_q    <= pkt_cnt_q + CWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_wr) buf_data[wr_ptr] <= mem_rd_data;
    end

endmodule

// File: tb/tb_pkt_egress_reader.sv
// tb/tb_pkt_egress_reader.sv - scoreboard bench for pkt_egress_reader
module tb_pkt_egress_reader;
    localparam int DW = 32, AW = 10, LW = 6, MW = 64, CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sch_valid, sch_deque_en;
    logic [DW-1:0] sch_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [MW-1:0] mem_rd_data = '0;
    logic          tx_valid, tx_ready, tx_sop, tx_eop;
    logic [MW-1:0] tx_data;
    logic          free_valid, busy;
    logic [AW-1:0] free_addr;
    logic [CW-1:0] pkt_cnt;

    pkt_egress_reader #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW), .MWIDTH(MW), .CWIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .sch_valid(sch_valid), .sch_deque_en(sch_deque_en), .sch_data(sch_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_sop(tx_sop), .tx_eop(tx_eop),
        .free_valid(free_valid), .free_addr(free_addr),
        .busy(busy), .pkt_cnt(pkt_cnt)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [MW-1:0] d;
        logic          sop;
        logic          eop;
    } word_t;

    word_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [AW-1:0] free_q[$];
    logic [DW-1:0] desc_q[$];
    logic [MW-1:0] ram [1024];

    int   vectors = 0, miscompares = 0;
    int   acc_cnt = 0, issued = 0, exp_cnt = 0;
    int   ready_mode = 0, rp = 0;
    bit   ready_pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};
    logic deq_seen = 1'b0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [79:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    // Stimulus: queue descriptor and the reads, words and release it must produce.
    task automatic send(input logic [AW-1:0] start, input int len);
        logic [AW-1:0] a;
        word_t w;
        desc_q.push_back({16'd0, LW'(len), start});
        for (int i = 0; i < len; i++) begin
            a     = start + AW'(i);
            w.d   = MW'(a) * 3;
            w.sop = (i == 0);
            w.eop = (i == len - 1);
            addr_q.push_back(a);
            exp_q.push_back(w);
        end
        free_q.push_back(start);
        if (len != 0) exp_cnt++;
    endtask

    task automatic wait_done(input int max_cycles);
        logic done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0 && addr_q.size() == 0 && free_q.size() == 0 &&
                    desc_q.size() == 0 && !busy);
        end
        check("drain_done", done, 1);
        repeat (2) @(negedge clk);
    endtask

    initial for (int i = 0; i < 1024; i++) ram[i] = MW'(i) * 3;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

    // Scheduler show-ahead FIFO and egress sink, updated just after each edge.
    initial begin
        sch_valid = 1'b0;
        sch_data  = '0;
        tx_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (deq_seen && desc_q.size() != 0) void'(desc_q.pop_front());
            deq_seen  = 1'b0;
            sch_valid = (desc_q.size() != 0);
            sch_data  = sch_valid ? desc_q[0] : '0;
            if (ready_mode == 1) begin
                tx_ready = ready_pat[rp];
                rp = (rp + 1) % 8;
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    initial begin
        word_t         w, prev;
        logic          prev_stall = 1'b0, free_due = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
                free_due   = 1'b0;
                issued     = acc_cnt;
            end else begin
                if (free_due || free_valid) begin
                    check("free_timing", free_valid, free_due);
                    if (free_valid) begin
                        if (free_q.size() == 0) unexpected("free_extra", free_addr);
                        else check("free_addr", free_addr, free_q.pop_front());
                    end
                end
                free_due = 1'b0;
                if (sch_deque_en) begin
                    check("deque_gate", sch_valid, 1);
                    deq_seen = 1'b1;
                    if (sch_data[AW+LW-1:AW] == '0) free_due = 1'b1;
                end
                if (mem_rd_en) begin
                    check("credit", (issued - acc_cnt - int'(tx_valid && tx_ready)) < 2, 1);
                    issued++;
                    if (addr_q.size() == 0) unexpected("rd_extra", mem_rd_addr);
                    else check("rd_addr", mem_rd_addr, addr_q.pop_front());
                end
                if (prev_stall) check("stall_hold", {tx_valid, tx_data, tx_sop, tx_eop}, {1'b1, prev});
                if (tx_valid && tx_ready) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) unexpected("tx_extra", tx_data);
                    else begin
                        w = exp_q.pop_front();
                        check("tx_word", {tx_data, tx_sop, tx_eop}, w);
                    end
                    if (tx_eop) free_due = 1'b1;
                end
                prev_stall = tx_valid && !tx_ready;
                prev       = {tx_data, tx_sop, tx_eop};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, base;
        logic seen;
        // 1: reset state
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_free", {free_valid, free_addr}, 0);
        check("rst_rd", {mem_rd_en, mem_rd_addr}, 0);
        check("rst_deque", sch_deque_en, 0);
        rst = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | mem_rd_en | busy | tx_valid | free_valid;
        end
        check("idle_quiet", seen, 0);

        // 2: single packet at full rate, first word two cycles after the pop
        send(10'h010, 4);
        for (int i = 0; i < 10 && !sch_deque_en; i++) @(negedge clk);
        n = 0;
        for (int i = 0; i < 10 && !(n > 0 && tx_valid); i++) begin
            @(negedge clk);
            n++;
        end
        check("first_word_latency", n, 2);
        wait_done(100);
        check("pkt_cnt_t2", pkt_cnt, exp_cnt);

        // 3: backpressure with a toggling sink
        ready_mode = 1;
        send(10'h010, 4);
        send(10'h100, 10);
        wait_done(300);
        ready_mode = 0;
        check("pkt_cnt_t3", pkt_cnt, exp_cnt);

        // 4: address wrap, then a single-word packet
        send(10'h3FF, 3);
        send(10'h020, 1);
        wait_done(100);
        check("pkt_cnt_t4", pkt_cnt, exp_cnt);

        // 5: zero length followed back-to-back by a short packet
        send(10'h040, 0);
        send(10'h050, 2);
        wait_done(100);
        check("pkt_cnt_t5", pkt_cnt, exp_cnt);

        // 6: reset after three of eight words
        base = acc_cnt;
        send(10'h180, 8);
        for (int i = 0; i < 200 && acc_cnt < base + 3; i++) @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        free_q.delete();
        desc_q.delete();
        exp_cnt = 0;
        #1;
        check("midrst_acc", acc_cnt, base + 3);
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_free", free_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pkt_cnt", pkt_cnt, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send(10'h200, 2);
        wait_done(100);
        check("pkt_cnt_t6", pkt_cnt, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
